// File: rtl/sap4_ab_alu_datapath.sv
// SAP-4 accumulator datapath: A and B registers with the shared ALU.
// Output buses are gated by their enables and read as 0 when disabled.
module sap4_ab_alu_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] ram_to_a,
    input  logic [WIDTH-1:0] ram_to_b,
    input  logic [WIDTH-1:0] tmp_in,
    input  logic             carry_in,
    input  logic             la_ram,
    input  logic             la_b,
    input  logic             la_alu,
    input  logic             lb_tmp,
    input  logic             lb_alu,
    input  logic             lb_pop,
    input  logic             lb_carry,
    input  logic             ea_tmp,
    input  logic             ea_ram,
    input  logic             ea_out,
    input  logic             ea_carry,
    input  logic             eb_a,
    input  logic             eb_push,
    input  logic             eb_rcl,
    input  logic             eu,
    output logic [WIDTH-1:0] a_to_tmp,
    output logic [WIDTH-1:0] a_to_ram,
    output logic [WIDTH-1:0] a_to_out,
    output logic [WIDTH-1:0] b_to_ram,
    output logic             carry_from_a,
    output logic             carry_from_b,
    output logic             alu_zero,
    output logic             alu_carry,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q
);

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] a_res;
    logic [WIDTH-1:0] b_res;
    logic [WIDTH:0]   wide;
    logic             cy;
    logic             dest_b;

    // ALU: result per opcode, everything forced low when eu is off
    always_comb begin
        a_res  = a_q;
        b_res  = b_q;
        cy     = 1'b0;
        dest_b = 1'b0;
        wide   = '0;
        case (opcode)
            4'b0001: begin
                wide  = {1'b0, a_q} + {1'b0, b_q};
                a_res = wide[WIDTH-1:0];
                cy    = wide[WIDTH];
            end
            4'b0010: begin
                wide  = {1'b0, a_q} - {1'b0, b_q};
                a_res = wide[WIDTH-1:0];
                cy    = wide[WIDTH];
            end
            4'b0101: begin
                a_res = {1'b0, a_q[WIDTH-1:1]};
                cy    = a_q[0];
            end
            4'b0100: begin
                b_res  = {b_q[WIDTH-2:0], carry_in};
                cy     = b_q[WIDTH-1];
                dest_b = 1'b1;
            end
            4'b1000: begin
                wide  = {1'b0, a_q} + {1'b0, tmp_in};
                a_res = wide[WIDTH-1:0];
                cy    = wide[WIDTH];
            end
            4'b1001: begin
                wide  = {1'b0, a_q} - {1'b0, tmp_in};
                a_res = wide[WIDTH-1:0];
                cy    = wide[WIDTH];
            end
            default: ;
        endcase
        if (!eu) begin
            a_res  = '0;
            b_res  = '0;
            cy     = 1'b0;
        end
    end

    assign alu_carry = cy;
    assign alu_zero  = eu & (dest_b ? (b_res == '0) : (a_res == '0));

    // A next state: ALU beats B beats RAM; B path reads 0 unless eb_a
    always_comb begin
        a_d = a_q;
        if (la_alu)
            a_d = a_res;
        else if (la_b)
            a_d = eb_a ? b_q : '0;
        else if (la_ram)
            a_d = ram_to_a;
    end

    // B next state: ALU, then POP, then TMP, then carry flag
    always_comb begin
        b_d = b_q;
        if (lb_alu)
            b_d = b_res;
        else if (lb_pop)
            b_d = ram_to_b;
        else if (lb_tmp)
            b_d = tmp_in;
        else if (lb_carry)
            b_d = {{(WIDTH-1){1'b0}}, carry_in};
    end

    // Both registers sample pre-edge values so XCHG works in one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_to_tmp     = ea_tmp ? a_q : '0;
    assign a_to_ram     = ea_ram ? a_q : '0;
    assign a_to_out     = ea_out ? a_q : '0;
    assign b_to_ram     = eb_push ? b_q : '0;
    assign carry_from_a = ea_carry & a_q[0];
    assign carry_from_b = eb_rcl & b_q[WIDTH-1];

endmodule

// File: tb/tb_sap4_ab_alu_datapath.sv
// Directed bench for the SAP-4 A/B/ALU datapath.
// Each task drives one scenario and checks against hand-computed values.
module tb_sap4_ab_alu_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [3:0] ram_to_a, ram_to_b, tmp_in;
    logic       carry_in;
    logic       la_ram, la_b, la_alu;
    logic       lb_tmp, lb_alu, lb_pop, lb_carry;
    logic       ea_tmp, ea_ram, ea_out, ea_carry;
    logic       eb_a, eb_push, eb_rcl, eu;
    logic [3:0] a_to_tmp, a_to_ram, a_to_out, b_to_ram;
    logic       carry_from_a, carry_from_b, alu_zero, alu_carry;
    logic [3:0] a_q, b_q;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sap4_ab_alu_datapath #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .ram_to_a(ram_to_a), .ram_to_b(ram_to_b), .tmp_in(tmp_in),
        .carry_in(carry_in),
        .la_ram(la_ram), .la_b(la_b), .la_alu(la_alu),
        .lb_tmp(lb_tmp), .lb_alu(lb_alu), .lb_pop(lb_pop),
        .lb_carry(lb_carry),
        .ea_tmp(ea_tmp), .ea_ram(ea_ram), .ea_out(ea_out),
        .ea_carry(ea_carry),
        .eb_a(eb_a), .eb_push(eb_push), .eb_rcl(eb_rcl), .eu(eu),
        .a_to_tmp(a_to_tmp), .a_to_ram(a_to_ram), .a_to_out(a_to_out),
        .b_to_ram(b_to_ram),
        .carry_from_a(carry_from_a), .carry_from_b(carry_from_b),
        .alu_zero(alu_zero), .alu_carry(alu_carry),
        .a_q(a_q), .b_q(b_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {la_ram, la_b, la_alu} = '0;
        {lb_tmp, lb_alu, lb_pop, lb_carry} = '0;
        {ea_tmp, ea_ram, ea_out, ea_carry} = '0;
        {eb_a, eb_push, eb_rcl, eu} = '0;
    endtask

    task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
        ram_to_a = a;
        ram_to_b = b;
        la_ram = 1'b1;
        lb_pop = 1'b1;
        tick();
        la_ram = 1'b0;
        lb_pop = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        opcode = 4'h0;
        ram_to_a = 4'h0; ram_to_b = 4'h0; tmp_in = 4'h0;
        carry_in = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        total_cnt++;
        if (a_q !== 4'h0 || b_q !== 4'h0)
            $display("FAIL reset_regs a=%h b=%h want 0 0", a_q, b_q);
        else pass_cnt++;
        total_cnt++;
        if ({a_to_tmp, a_to_ram, a_to_out, b_to_ram, carry_from_a,
             carry_from_b, alu_zero, alu_carry} !== '0)
            $display("FAIL reset_outs got nonzero gated outputs");
        else pass_cnt++;
    endtask

    task automatic test_load_xchg();
        ram_to_a = 4'hA;
        la_ram = 1'b1;
        tick();
        la_ram = 1'b0;
        total_cnt++;
        if (a_q !== 4'hA) $display("FAIL la_ram a=%h want a", a_q);
        else pass_cnt++;
        ea_tmp = 1'b1;
        #1;
        total_cnt++;
        if (a_to_tmp !== 4'hA)
            $display("FAIL ea_tmp got %h want a", a_to_tmp);
        else pass_cnt++;
        ea_tmp = 1'b0;
        ram_to_b = 4'h3;
        lb_pop = 1'b1;
        tick();
        lb_pop = 1'b0;
        tmp_in = 4'hA;
        eb_a = 1'b1; la_b = 1'b1; lb_tmp = 1'b1;
        tick();
        idle();
        total_cnt++;
        if (a_q !== 4'h3 || b_q !== 4'hA)
            $display("FAIL xchg a=%h b=%h want 3 a", a_q, b_q);
        else pass_cnt++;
        eb_push = 1'b1;
        #1;
        total_cnt++;
        if (b_to_ram !== 4'hA)
            $display("FAIL push got %h want a", b_to_ram);
        else pass_cnt++;
        eb_push = 1'b0; eb_rcl = 1'b1; ea_carry = 1'b1;
        #1;
        total_cnt++;
        if (carry_from_a !== 1'b1 || carry_from_b !== 1'b1)
            $display("FAIL carries got %b%b want 11",
                     carry_from_a, carry_from_b);
        else pass_cnt++;
        idle();
        la_b = 1'b1;
        tick();
        la_b = 1'b0;
        total_cnt++;
        if (a_q !== 4'h0)
            $display("FAIL la_b_no_eb_a a=%h want 0", a_q);
        else pass_cnt++;
    endtask

    task automatic test_add();
        load_ab(4'h9, 4'h8);
        opcode = 4'b0001;
        eu = 1'b0;
        #1;
        total_cnt++;
        if (alu_carry !== 1'b0 || alu_zero !== 1'b0)
            $display("FAIL add_eu_off c=%b z=%b want 0 0",
                     alu_carry, alu_zero);
        else pass_cnt++;
        eu = 1'b1;
        #1;
        total_cnt++;
        if (alu_carry !== 1'b1 || alu_zero !== 1'b0)
            $display("FAIL add_flags c=%b z=%b want 1 0",
                     alu_carry, alu_zero);
        else pass_cnt++;
        la_alu = 1'b1;
        tick();
        la_alu = 1'b0;
        total_cnt++;
        if (a_q !== 4'h1) $display("FAIL add_res a=%h want 1", a_q);
        else pass_cnt++;
        load_ab(4'hF, 4'h0);
        opcode = 4'b1000;
        tmp_in = 4'h1;
        #1;
        total_cnt++;
        if (alu_carry !== 1'b1 || alu_zero !== 1'b1)
            $display("FAIL addtmp_flags c=%b z=%b want 1 1",
                     alu_carry, alu_zero);
        else pass_cnt++;
        eu = 1'b0;
    endtask

    task automatic test_sub();
        load_ab(4'h5, 4'h5);
        opcode = 4'b0010;
        eu = 1'b1;
        #1;
        total_cnt++;
        if (alu_zero !== 1'b1 || alu_carry !== 1'b0)
            $display("FAIL sub_eq z=%b c=%b want 1 0", alu_zero, alu_carry);
        else pass_cnt++;
        load_ab(4'h3, 4'h5);
        #1;
        total_cnt++;
        if (alu_zero !== 1'b0 || alu_carry !== 1'b1)
            $display("FAIL sub_borrow z=%b c=%b want 0 1",
                     alu_zero, alu_carry);
        else pass_cnt++;
        la_alu = 1'b1;
        tick();
        la_alu = 1'b0;
        total_cnt++;
        if (a_q !== 4'hE) $display("FAIL sub_res a=%h want e", a_q);
        else pass_cnt++;
        load_ab(4'h2, 4'h0);
        opcode = 4'b1001;
        tmp_in = 4'h2;
        #1;
        total_cnt++;
        if (alu_zero !== 1'b1 || alu_carry !== 1'b0)
            $display("FAIL subtmp z=%b c=%b want 1 0", alu_zero, alu_carry);
        else pass_cnt++;
        opcode = 4'b0000;
        load_ab(4'h7, 4'h0);
        #1;
        total_cnt++;
        if (alu_zero !== 1'b0 || alu_carry !== 1'b0)
            $display("FAIL nop_op z=%b c=%b want 0 0", alu_zero, alu_carry);
        else pass_cnt++;
        eu = 1'b0;
    endtask

    task automatic test_shr_rcl();
        load_ab(4'hB, 4'h9);
        opcode = 4'b0101;
        eu = 1'b1;
        #1;
        total_cnt++;
        if (alu_carry !== 1'b1) $display("FAIL shr_c got %b want 1", alu_carry);
        else pass_cnt++;
        la_alu = 1'b1; lb_alu = 1'b1;
        tick();
        la_alu = 1'b0; lb_alu = 1'b0;
        total_cnt++;
        if (a_q !== 4'h5 || b_q !== 4'h9)
            $display("FAIL shr_res a=%h b=%h want 5 9", a_q, b_q);
        else pass_cnt++;
        opcode = 4'b0100;
        carry_in = 1'b1;
        #1;
        total_cnt++;
        if (alu_carry !== 1'b1 || alu_zero !== 1'b0)
            $display("FAIL rcl_flags c=%b z=%b want 1 0",
                     alu_carry, alu_zero);
        else pass_cnt++;
        la_alu = 1'b1; lb_alu = 1'b1;
        tick();
        la_alu = 1'b0; lb_alu = 1'b0;
        total_cnt++;
        if (b_q !== 4'h3 || a_q !== 4'h5)
            $display("FAIL rcl_res a=%h b=%h want 5 3", a_q, b_q);
        else pass_cnt++;
        load_ab(4'h5, 4'h0);
        carry_in = 1'b0;
        #1;
        total_cnt++;
        if (alu_zero !== 1'b1 || alu_carry !== 1'b0)
            $display("FAIL rcl_zero z=%b c=%b want 1 0", alu_zero, alu_carry);
        else pass_cnt++;
        eu = 1'b0;
        carry_in = 1'b1;
        lb_carry = 1'b1;
        tick();
        lb_carry = 1'b0;
        total_cnt++;
        if (b_q !== 4'h1) $display("FAIL lb_carry b=%h want 1", b_q);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        ram_to_b = 4'h6;
        tmp_in = 4'hC;
        lb_pop = 1'b1; lb_tmp = 1'b1;
        tick();
        lb_pop = 1'b0; lb_tmp = 1'b0;
        total_cnt++;
        if (b_q !== 4'h6) $display("FAIL pop_prio b=%h want 6", b_q);
        else pass_cnt++;
        opcode = 4'b0000;
        eu = 1'b1;
        ram_to_a = 4'h2;
        la_alu = 1'b1; la_ram = 1'b1;
        tick();
        idle();
        total_cnt++;
        if (a_q !== 4'h5) $display("FAIL alu_prio a=%h want 5", a_q);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        ea_out = 1'b1;
        ram_to_a = 4'h9;
        la_ram = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (a_q !== 4'h0 || b_q !== 4'h0 || a_to_out !== 4'h0)
            $display("FAIL rst_async a=%h b=%h out=%h want 0",
                     a_q, b_q, a_to_out);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (a_q !== 4'h0) $display("FAIL rst_hold a=%h want 0", a_q);
        else pass_cnt++;
        la_ram = 1'b0;
        reset = 1'b1;
        tick();
        total_cnt++;
        if (a_q !== 4'h0) $display("FAIL rst_lost a=%h want 0", a_q);
        else pass_cnt++;
        idle();
    endtask

    initial begin
        test_reset();
        test_load_xchg();
        test_add();
        test_sub();
        test_shr_rcl();
        test_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sap4_ab_alu_datapath.md
Name: sap4_ab_alu_datapath

Overview:
- 4-bit accumulator datapath of the SAP-style teaching CPU: A register, B register and ALU in one block.
- Sits between RAM, TMP register, OUT register and flag register. All load/enable strobes come from the control sequencer; the instruction opcode (IR upper nibble) selects the ALU operation.
- Registers are clocked on the rising edge. The ALU and all output gating are combinational.

Parameters:
- WIDTH, 4, data width of A, B, ALU (all behaviour below is written for 4).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears A and B.
- opcode  in  4  IR opcode nibble, selects the ALU operation.
- ram_to_a  in  4  RAM data for A load (MOV A,[addr]).
- ram_to_b  in  4  RAM/stack data for B load (POP B).
- tmp_in  in  4  TMP register contents.
- carry_in  in  1  carry flag from flag register.
- la_ram, la_b, la_alu  in  1 each  A load strobes: from RAM / from B / from ALU.
- lb_tmp, lb_alu, lb_pop, lb_carry  in  1 each  B load strobes: from TMP / ALU / RAM / carry.
- ea_tmp, ea_ram, ea_out, ea_carry  in  1 each  A output enables.
- eb_a, eb_push, eb_rcl  in  1 each  B output enables: to A path / to RAM / carry-out-of-B.
- eu  in  1  ALU output enable.
- a_to_tmp, a_to_ram, a_to_out  out  4  gated A value.
- b_to_ram  out  4  gated B value (PUSH B).
- carry_from_a  out  1  gated A[0].
- carry_from_b  out  1  gated B[3].
- alu_zero, alu_carry  out  1  ALU flags to flag register.
- a_q, b_q  out  4  raw register contents (debug/observability).

Behaviour:
- Reset low, asynchronous: A=0 and B=0 immediately, held while low. All gated outputs then follow their enables (0 when enable low).
- A load, one per rising edge, priority la_alu > la_b > la_ram:
  - la_alu: A <= ALU A-result.
  - la_b: A <= B. Requires eb_a=1; if eb_a=0, A is loaded with 0.
  - la_ram: A <= ram_to_a.
  - No strobe: A holds.
- B load, priority lb_alu > lb_pop > lb_tmp > lb_carry:
  - lb_alu: B <= ALU B-result.
  - lb_pop: B <= ram_to_b.
  - lb_tmp: B <= tmp_in.
  - lb_carry: B <= {000, carry_in}.
  - No strobe: B holds.
- A and B both sample pre-edge values. Same-edge la_b + lb_tmp therefore completes XCHG phase 3 correctly (A gets old B, B gets TMP).
- Output gating: each gated bus equals its source when its enable is 1, otherwise 0. eb_a has no visible port; it qualifies the B->A path only.
- ALU is combinational. Outputs are forced to 0 (results and flags) when eu=0.
- ALU ops by opcode (A-res / B-res, carry):
  - 0001 ADD A,B: A-res = A+B; carry = bit 4 of the sum.
  - 0010 SUB A,B: A-res = A-B mod 16; carry = borrow (1 when A<B).
  - 0101 SHR A: A-res = A>>1 with MSB=0; carry = old A[0].
  - 0100 RCL B: B-res = {B[2:0], carry_in}; carry = old B[3].
  - 1000 ADD A,TMP: A + tmp_in, carry as ADD.
  - 1001 SUB A,TMP: A - tmp_in, borrow as SUB.
  - All other opcodes: results = A (A-res) and B (B-res), carry=0.
- The B-result equals B for every op except RCL. The A-result equals A for RCL.
- alu_zero = 1 when the op's destination result is 0 (B-res for RCL, A-res otherwise), and only when eu=1.
- Wrap-around: all arithmetic is modulo 16; overflow is reported only through alu_carry.
- Reset mid-operation: registers clear at once and pending loads are discarded. Combinational outputs recompute from the zeroed registers.

Test Plan:
- Reset low, then high, no strobes -> a_q=0, b_q=0, all gated outputs 0.
- ram_to_a=0xA, la_ram edge -> a_q=0xA. Then ea_tmp=1 -> a_to_tmp=0xA. Then eb_a+la_b with lb_tmp, tmp_in=0xA, B=0x3 -> A=0x3, B=0xA. eb_push=1 -> b_to_ram=0xA.
- A=9, B=8, opcode 0001, eu=1 -> alu A-res 0x1, carry=1, zero=0. la_alu edge -> a_q=0x1.
- SUB: A=5, B=5 -> 0, zero=1, carry=0. A=3, B=5 -> 0xE, carry=1, zero=0.
- SHR: A=0xB -> 0x5, carry=1. RCL: B=0x9, carry_in=1, lb_alu -> B=0x3, carry=1. RCL: B=0x0, carry_in=0 -> zero=1.
- lb_pop with ram_to_b=0x6 and lb_tmp simultaneously -> B=0x6. Assert reset mid-cycle with la_ram pending -> A=0 immediately, load lost.
